// File: rtl/pacman_mover.sv
// pacman_mover: tile-level Pac-Man movement controller.
// Probes the wall memory for the buffered turn, then the current heading, then steps.
module pacman_mover #(
    parameter int MAP_W           = 40,
    parameter int MAP_H           = 30,
    parameter int START_X         = 19,
    parameter int START_Y         = 22,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [7:0]  keycode,
    input  logic        wall_in,
    output logic [10:0] query_pos,
    output logic [5:0]  pac_x,
    output logic [4:0]  pac_y,
    output logic [10:0] pac_pos,
    output logic [1:0]  dir,
    output logic        moving,
    output logic        move_done
);

    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [5:0] XMAX = 6'(MAP_W - 1);
    localparam logic [4:0] YMAX = 5'(MAP_H - 1);
    localparam logic [5:0] SX = 6'(START_X);
    localparam logic [4:0] SY = 5'(START_Y);
    localparam logic [10:0] SPOS = 11'(START_Y * MAP_W + START_X);

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_LEFT  = 2'b11;

    typedef enum logic [2:0] {IDLE, QD, CD, QC, CC} state_t;

    typedef struct packed {
        logic       blk;
        logic [5:0] x;
        logic [4:0] y;
    } tile_t;

    state_t      state_q, state_d;
    logic [1:0]  want_q, want_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic        step_req_q, step_req_d;
    logic        consume;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [10:0] pos_q, pos_d;
    logic [1:0]  dir_q, dir_d;
    logic        moving_q, moving_d;
    logic        done_q, done_d;
    logic [10:0] qpos_q, qpos_d;
    logic        qblk_q, qblk_d;
    logic [5:0]  tx_q, tx_d;
    logic [4:0]  ty_q, ty_d;
    logic [1:0]  tdir_q, tdir_d;
    tile_t       nw, nd;

    // y*40 + x as shifts; fits 11 bits for every legal tile
    function automatic logic [10:0] idx(input logic [5:0] x, input logic [4:0] y);
        logic [10:0] yy;
        yy = {6'b0, y};
        return (yy << 5) + (yy << 3) + {5'b0, x};
    endfunction

    // Neighbour tile with horizontal tunnel wrap and hard top/bottom edges
    function automatic tile_t nbr(input logic [5:0] x, input logic [4:0] y,
                                  input logic [1:0] d);
        tile_t t;
        t.blk = 1'b0;
        t.x   = x;
        t.y   = y;
        case (d)
            D_UP: begin
                if (y == 5'd0) t.blk = 1'b1;
                else t.y = y - 5'd1;
            end
            D_RIGHT: t.x = (x == XMAX) ? 6'd0 : x + 6'd1;
            D_DOWN: begin
                if (y == YMAX) t.blk = 1'b1;
                else t.y = y + 5'd1;
            end
            default: t.x = (x == 6'd0) ? XMAX : x - 6'd1;
        endcase
        return t;
    endfunction

    // Keyboard decode: buffer the latest direction key
    always_comb begin
        want_d = want_q;
        case (keycode)
            8'h1A:   want_d = D_UP;
            8'h07:   want_d = D_RIGHT;
            8'h16:   want_d = D_DOWN;
            8'h04:   want_d = D_LEFT;
            default: want_d = want_q;
        endcase
    end

    // Frame divider; a wrap tick wins over consumption so no step is lost
    always_comb begin
        fcnt_d     = fcnt_q;
        step_req_d = step_req_q;
        if (consume) step_req_d = 1'b0;
        if (frame_tick) begin
            if (fcnt_q == FLAST) begin
                fcnt_d     = '0;
                step_req_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Step evaluation FSM: probe wanted tile, fall back to current heading
    always_comb begin
        state_d  = state_q;
        consume  = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        done_d   = 1'b0;
        qpos_d   = qpos_q;
        qblk_d   = qblk_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        tdir_d   = tdir_q;
        nw       = nbr(x_q, y_q, want_q);
        nd       = nbr(x_q, y_q, dir_q);
        case (state_q)
            IDLE: begin
                if (step_req_q) begin
                    consume = 1'b1;
                    qblk_d  = nw.blk;
                    tx_d    = nw.x;
                    ty_d    = nw.y;
                    tdir_d  = want_q;
                    qpos_d  = nw.blk ? pos_q : idx(nw.x, nw.y);
                    state_d = QD;
                end
            end
            QD: state_d = CD;
            CD: begin
                if (!qblk_q && !wall_in) begin
                    x_d      = tx_q;
                    y_d      = ty_q;
                    pos_d    = qpos_q;
                    dir_d    = tdir_q;
                    moving_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    qblk_d  = nd.blk;
                    tx_d    = nd.x;
                    ty_d    = nd.y;
                    tdir_d  = dir_q;
                    qpos_d  = nd.blk ? pos_q : idx(nd.x, nd.y);
                    state_d = QC;
                end
            end
            QC: state_d = CC;
            CC: begin
                if (!qblk_q && !wall_in) begin
                    x_d      = tx_q;
                    y_d      = ty_q;
                    pos_d    = qpos_q;
                    moving_d = 1'b1;
                end else begin
                    moving_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            want_q     <= D_LEFT;
            fcnt_q     <= '0;
            step_req_q <= 1'b0;
            x_q        <= SX;
            y_q        <= SY;
            pos_q      <= SPOS;
            dir_q      <= D_LEFT;
            moving_q   <= 1'b0;
            done_q     <= 1'b0;
            qpos_q     <= '0;
            qblk_q     <= 1'b0;
            tx_q       <= SX;
            ty_q       <= SY;
            tdir_q     <= D_LEFT;
        end else begin
            state_q    <= state_d;
            want_q     <= want_d;
            fcnt_q     <= fcnt_d;
            step_req_q <= step_req_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            done_q     <= done_d;
            qpos_q     <= qpos_d;
            qblk_q     <= qblk_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            tdir_q     <= tdir_d;
        end
    end

    assign query_pos = qpos_q;
    assign pac_x     = x_q;
    assign pac_y     = y_q;
    assign pac_pos   = pos_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign move_done = done_q;

endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: directed bench with a registered wall-memory model.
// Walks the sprite across the maze and checks steps, wraps, edges and reset.
module tb_pacman_mover;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic        wall_in = 1'b0;
    logic [10:0] query_pos;
    logic [5:0]  pac_x;
    logic [4:0]  pac_y;
    logic [10:0] pac_pos;
    logic [1:0]  dir;
    logic        moving;
    logic        move_done;

    bit          wall_mem [0:2047];
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          seen;
    logic [10:0] qlog [0:31];

    pacman_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .wall_in(wall_in), .query_pos(query_pos), .pac_x(pac_x), .pac_y(pac_y),
        .pac_pos(pac_pos), .dir(dir), .moving(moving), .move_done(move_done)
    );

    always #5 Clk = ~Clk;

    // Synchronous wall lookup stage
    always_ff @(posedge Clk) wall_in <= wall_mem[query_pos];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        keycode = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        @(negedge Clk);
        keycode = 8'h00;
    endtask

    task automatic run_step(input int nticks);
        for (int i = 0; i < nticks; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
        lat = 0;
        while (!move_done && lat < 20) begin
            @(negedge Clk);
            lat++;
            qlog[lat] = query_pos;
        end
        chk("step_timeout", int'(move_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) wall_mem[i] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_x", int'(pac_x), 19);
        chk("rst_y", int'(pac_y), 22);
        chk("rst_pos", int'(pac_pos), 899);
        chk("rst_dir", int'(dir), 3);
        chk("rst_moving", int'(moving), 0);
        chk("rst_done", int'(move_done), 0);
        chk("rst_query", int'(query_pos), 0);
        Reset = 1'b0;

        run_step(8);
        chk("t1_lat", lat, 3);
        chk("t1_q", int'(qlog[1]), 898);
        chk("t1_x", int'(pac_x), 18);
        chk("t1_pos", int'(pac_pos), 898);
        chk("t1_dir", int'(dir), 3);
        chk("t1_moving", int'(moving), 1);

        do_reset();
        wall_mem[859] = 1'b1;
        press(8'h1A);
        run_step(8);
        chk("t2_lat", lat, 5);
        chk("t2_qd", int'(qlog[1]), 859);
        chk("t2_qc", int'(qlog[3]), 898);
        chk("t2_x", int'(pac_x), 18);
        chk("t2_dir", int'(dir), 3);
        chk("t2_moving", int'(moving), 1);

        do_reset();
        wall_mem[898] = 1'b1;
        press(8'h1A);
        run_step(8);
        chk("t3_lat", lat, 5);
        chk("t3_pos", int'(pac_pos), 899);
        chk("t3_moving", int'(moving), 0);
        chk("t3_dir", int'(dir), 3);
        wall_mem[859] = 1'b0;
        run_step(8);
        chk("t3b_lat", lat, 3);
        chk("t3b_y", int'(pac_y), 21);
        chk("t3b_pos", int'(pac_pos), 859);
        chk("t3b_dir", int'(dir), 0);
        chk("t3b_moving", int'(moving), 1);
        wall_mem[898] = 1'b0;

        for (int i = 0; i < 7; i++) run_step(8);
        chk("t4_y14", int'(pac_pos), 579);
        press(8'h04);
        for (int i = 0; i < 19; i++) run_step(8);
        chk("t4_x0", int'(pac_pos), 560);
        chk("t4_dirl", int'(dir), 3);
        run_step(8);
        chk("t4_wrapl_x", int'(pac_x), 39);
        chk("t4_wrapl_pos", int'(pac_pos), 599);
        press(8'h07);
        run_step(8);
        chk("t4_wrapr_x", int'(pac_x), 0);
        chk("t4_wrapr_pos", int'(pac_pos), 560);
        chk("t4_wrapr_dir", int'(dir), 1);

        press(8'h1A);
        for (int i = 0; i < 14; i++) run_step(8);
        chk("t5_top_pos", int'(pac_pos), 0);
        chk("t5_top_dir", int'(dir), 0);
        press(8'h07);
        run_step(8);
        chk("t5_r_pos", int'(pac_pos), 1);
        press(8'h1A);
        run_step(8);
        chk("t5_lat", lat, 5);
        chk("t5_qd", int'(qlog[1]), 1);
        chk("t5_qc", int'(qlog[3]), 2);
        chk("t5_x", int'(pac_x), 2);
        chk("t5_y", int'(pac_y), 0);
        chk("t5_dir", int'(dir), 1);
        chk("t5_moving", int'(moving), 1);

        for (int i = 0; i < 8; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("t6_inqc", int'(query_pos), 3);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t6_x", int'(pac_x), 19);
        chk("t6_y", int'(pac_y), 22);
        chk("t6_pos", int'(pac_pos), 899);
        chk("t6_dir", int'(dir), 3);
        chk("t6_moving", int'(moving), 0);
        chk("t6_done", int'(move_done), 0);
        chk("t6_query", int'(query_pos), 0);
        Reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (move_done) seen++;
        end
        chk("t6_nodone", seen, 0);
        run_step(1);
        chk("t6_lat", lat, 3);
        chk("t6_after_x", int'(pac_x), 18);
        chk("t6_after_pos", int'(pac_pos), 898);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Tile-level movement controller for the Pac-Man sprite. Once every FRAMES_PER_STEP frames it probes the maze wall memory through the synchronous wall-lookup stage downstream: first the tile in the buffered keyboard direction, then the tile in the current direction. It then commits one tile step or stops. Its pac_pos output feeds the wall-lookup/sprite stage, and its query_pos output drives that stage's primary lookup port, whose registered is_wall result returns as wall_in.

## Interface
- MAP_W, 40, maze width in tiles
- MAP_H, 30, maze height in tiles
- START_X, 19, reset tile column
- START_Y, 22, reset tile row
- FRAMES_PER_STEP, 8, frame ticks per movement step (≥1)
- Clk  in  1  system clock; one clock domain
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- keycode  in  8  USB HID keycode: 0x1A up, 0x07 right, 0x16 down, 0x04 left; other values are ignored
- wall_in  in  1  registered wall bit for query_pos, valid 2 cycles after query_pos changes
- query_pos  out  11  tile index probed in the wall memory, = y*MAP_W + x
- pac_x  out  6  current tile column
- pac_y  out  5  current tile row
- pac_pos  out  11  pac_y*MAP_W + pac_x
- dir  out  2  current heading: 00 up, 01 right, 10 down, 11 left
- moving  out  1  high if the last step moved pac-man
- move_done  out  1  one-cycle pulse when a step evaluation completes

## Operation
- Desired-direction register want: loaded on every cycle where keycode matches a direction code. It holds otherwise, which buffers turns.
- Frame divider fcnt (0..FRAMES_PER_STEP-1): increments on frame_tick. On wrap it sets step_req.
  - step_req is sticky until consumed in IDLE.
  - A tick that coincides with consumption sets it again.
- FSM states: IDLE, QD, CD, QC, CC.
  - IDLE: if step_req is set, clear it. Register query_pos = nbr(want) and go to QD.
  - QD: wait one cycle; the wall stage samples query_pos.
  - CD: wall_in is valid.
    - If the tile is free: dir←want, move to nbr(want), moving←1, pulse move_done, go to IDLE.
    - If blocked: register query_pos = nbr(dir) and go to QC.
  - QC: wait one cycle.
  - CC:
    - If the tile is free: move to nbr(dir), moving←1.
    - If blocked: position and dir hold, moving←0.
    - In both cases, pulse move_done and go to IDLE.
- Neighbour rules (nbr):
  - Left from x=0 goes to x=MAP_W-1. Right from x=MAP_W-1 goes to x=0 (tunnel wrap).
  - Up from y=0 or down from y=MAP_H-1 is treated as blocked without using wall_in. query_pos is still driven with the current pac_pos.
- Index arithmetic: y*40+x computed as (y<<5)+(y<<3)+x in 11 bits, max 1199, with no overflow.
- pac_pos is registered and updates in the same cycle as pac_x/pac_y.
- want equal to dir is legal. In that case the CD check already covers straight motion: a blocked CD leads to a QC probe of the same tile, which stops pac-man.

## Timing
- Reset values:
  - pac_x=START_X, pac_y=START_Y, pac_pos=START_Y*MAP_W+START_X (899)
  - dir=11, want=11, moving=0, move_done=0
  - query_pos=0, fcnt=0, step_req=0, state IDLE
- Latency from step_req set to move_done:
  - 3 cycles if the desired direction is free (IDLE→QD→CD).
  - 5 cycles if it is blocked (IDLE→QD→CD→QC→CC).
- Position and dir update on the clock edge that ends CD or CC. move_done is high during the cycle after that edge.
- Reset asserted mid-evaluation: the FSM returns to IDLE immediately and all outputs take reset values. The pending step is discarded.
- A keycode change during QD–CC does not affect the in-flight decision. want updates, and the new value is used on the next step.

## Test plan
- Reset, then 8 frame_ticks with no walls: move_done after 3 cycles, pac_x=18, pac_pos=898, dir=11, moving=1.
- keycode=0x1A with a wall at 859 and 898 free: CD is blocked, QC probes 898, pac_x=18, dir stays 11, move_done after 5 cycles.
- Walls at 859 and 898: pac-man holds at 899 and moving=0. Then clear 859: the next step moves to y=21, pac_pos=859, dir=00.
- Place at x=0,y=14 heading left, no walls: after one step pac_x=39 and pac_pos=599. Heading right from x=39 gives pac_x=0.
- At y=0 with keycode=0x1A: no up move, the current direction is used, and query_pos=pac_pos during QD.
- Assert Reset during QC: all outputs return to reset values on the next sample, and there is no move_done until 8 further frame_ticks.
